// File: rtl/pipe_pkg.sv
// Purpose: shared constants, decode enums and width helper for pipeline stage registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

    // Field counts of the stage registers this block replaces.
    localparam int MEMWB_FIELDS = 3;
    localparam int EXMEM_FIELDS = 4;

    // Field positions inside the packed data word (field 0 in the LSBs).
    localparam int F_ALU = 0;
    localparam int F_LD  = 1;
    localparam int F_PC  = 2;

    // What the main entry does at the next edge.
    typedef enum logic [1:0] {
        M_KEEP,
        M_LOAD_IN,
        M_LOAD_S,
        M_CLEAR
    } m_op_e;

    // What the skid entry does at the next edge.
    typedef enum logic [1:0] {
        S_KEEP,
        S_LOAD_IN,
        S_CLEAR
    } s_op_e;

    function automatic int data_w(input int num_fields, input int field_w);
        return num_fields * field_w;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// Purpose: one storage slot of a stage register, valid bit plus data word.
// Latency: load/clear take effect at the next rising edge of clk.
// Backpressure: none; the owner decides when to load or clear.
//
// Ports: clk, rst (async, active-high), load (capture load_data, set valid),
//        clear (drop valid, data kept), valid/data (registered contents).
module pipe_entry #(
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              vld_q;
    logic              vld_d;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] dat_d;

    // A load wins over a clear: a slot being refilled is never left empty.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = load_data;
        end else if (clear) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign valid = vld_q;
    assign data  = dat_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised CPU stage register with valid/ready, optional skid slot, hold freeze and flush.
// Latency: 1 cycle from in_fire to out_valid when the stage is empty; 1 beat/cycle sustained.
// Backpressure: SKID=1 registers in_ready (~skid valid); SKID=0 in_ready = ~out_valid | out_ready; hold forces in_ready=0.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data upstream side;
//        kill drops the accepted beat; hold freezes the stage; flush empties it;
//        out_valid/out_ready/out_data downstream side; occupancy = stored beats;
//        hold_cycles = saturating count of cycles with hold=1.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int NUM_FIELDS = MEMWB_FIELDS,
    parameter int FIELD_W    = 32,
    parameter int SKID       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    input  logic                          kill,
    input  logic                          hold,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    output logic [1:0]                    occupancy,
    output logic [CNT_W-1:0]              hold_cycles
);

    localparam int DW = data_w(NUM_FIELDS, FIELD_W);

    logic          m_vld;
    logic [DW-1:0] m_dat;
    logic          s_vld;
    logic [DW-1:0] s_dat;

    logic          in_fire;
    logic          out_fire;
    logic          store;
    m_op_e         m_op;
    s_op_e         s_op;

    logic          in_rdy_q;
    logic          in_rdy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // in_ready never looks at m_op/s_op, so there is no combinational loop.
    // With SKID=1 it comes straight from a flop: out_ready never reaches it.
    assign in_ready = (SKID != 0) ? (in_rdy_q & ~hold)
                                  : ((~m_vld | out_ready) & ~hold);

    always_comb begin
        out_fire = m_vld & out_ready & ~hold;
        in_fire  = in_valid & in_ready;
        store    = in_fire & ~kill;
        m_op     = M_KEEP;
        s_op     = S_KEEP;

        // hold needs no branch of its own: it already blocks in_fire and out_fire.
        if (flush) begin
            m_op = M_CLEAR;
            s_op = S_CLEAR;
        end else if (out_fire) begin
            if (s_vld) begin
                m_op = M_LOAD_S;
                s_op = store ? S_LOAD_IN : S_CLEAR;
            end else begin
                m_op = store ? M_LOAD_IN : M_CLEAR;
            end
        end else if (store) begin
            if (!m_vld) begin
                m_op = M_LOAD_IN;
            end else begin
                s_op = S_LOAD_IN;
            end
        end
    end

    pipe_entry #(.DATA_W(DW)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      ((m_op == M_LOAD_IN) || (m_op == M_LOAD_S)),
        .clear     (m_op == M_CLEAR),
        .load_data ((m_op == M_LOAD_S) ? s_dat : in_data),
        .valid     (m_vld),
        .data      (m_dat)
    );

    // Without a skid slot the entry is never loaded and trims away to constants.
    pipe_entry #(.DATA_W(DW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      ((SKID != 0) && (s_op == S_LOAD_IN)),
        .clear     (s_op == S_CLEAR),
        .load_data (in_data),
        .valid     (s_vld),
        .data      (s_dat)
    );

    // in_ready for the next cycle is the inverse of the skid slot's next valid.
    always_comb begin
        in_rdy_d = ~s_vld;
        if (s_op == S_LOAD_IN && SKID != 0) begin
            in_rdy_d = 1'b0;
        end else if (s_op == S_CLEAR) begin
            in_rdy_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hold && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rdy_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            in_rdy_q <= in_rdy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = m_vld;
    assign out_data    = m_dat;
    assign occupancy   = {1'b0, m_vld} + {1'b0, s_vld};
    assign hold_cycles = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: self-checking bench for pipe_stage_reg, SKID=1 (CNT_W=4) and SKID=0 instances side by side.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [95:0] in_data;
    logic        kill;
    logic        hold;
    logic        flush;
    logic        out_ready;

    logic        ir1, ov1, ir0, ov0;
    logic [95:0] od1, od0;
    logic [1:0]  oc1, oc0;
    logic [3:0]  hc1;
    logic [15:0] hc0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: index 1 = skid instance, index 0 = single-entry instance.
    logic [95:0] mb [2][2];
    int          msz  [2];
    int          mcnt [2];
    int          cmax [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.NUM_FIELDS(3), .FIELD_W(32), .SKID(1), .CNT_W(4)) u_dut_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .kill(kill), .hold(hold), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .occupancy(oc1), .hold_cycles(hc1)
    );

    pipe_stage_reg #(.NUM_FIELDS(3), .FIELD_W(32), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .kill(kill), .hold(hold), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .occupancy(oc0), .hold_cycles(hc0)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy(input int i);
        if (hold) return 1'b0;
        if (i == 1) return msz[1] < 2;
        return (msz[0] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            msz[i]  = 0;
            mcnt[i] = 0;
        end
    endtask

    // One clock edge of the queue-level model, from pre-edge inputs and state.
    task automatic model_step();
        bit rdy [2];
        bit ofire [2];
        for (int i = 0; i < 2; i++) begin
            rdy[i]   = exp_rdy(i);
            ofire[i] = (msz[i] > 0) && out_ready && !hold;
        end
        for (int i = 0; i < 2; i++) begin
            if (hold && mcnt[i] < cmax[i]) mcnt[i]++;
            if (flush) begin
                msz[i] = 0;
            end else begin
                if (ofire[i]) begin
                    mb[i][0] = mb[i][1];
                    msz[i]--;
                end
                if (in_valid && rdy[i] && !kill && msz[i] < 2) begin
                    mb[i][msz[i]] = in_data;
                    msz[i]++;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, " in_ready skid"},      96'(ir1), 96'(exp_rdy(1)));
        chk({ph, " out_valid skid"},     96'(ov1), 96'(msz[1] > 0));
        if (msz[1] > 0) chk({ph, " out_data skid"}, od1, mb[1][0]);
        chk({ph, " occupancy skid"},     96'(oc1), 96'(msz[1]));
        chk({ph, " hold_cycles skid"},   96'(hc1), 96'(mcnt[1]));
        chk({ph, " in_ready noskid"},    96'(ir0), 96'(exp_rdy(0)));
        chk({ph, " out_valid noskid"},   96'(ov0), 96'(msz[0] > 0));
        if (msz[0] > 0) chk({ph, " out_data noskid"}, od0, mb[0][0]);
        chk({ph, " occupancy noskid"},   96'(oc0), 96'(msz[0]));
        chk({ph, " hold_cycles noskid"}, 96'(hc0), 96'(mcnt[0]));
    endtask

    // Inputs are applied at posedge+1; checks run at posedge+3.
    task automatic settle(input string ph);
        #2;
        check_all(ph);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string ph);
        settle(ph);
        advance();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        kill     = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        logic [95:0] vals [3];
        vals[0] = 96'h11;
        vals[1] = 96'h22;
        vals[2] = 96'h33;
        cmax[0] = 65535;
        cmax[1] = 15;

        // Reset
        rst = 1'b1;
        idle_in();
        out_ready = 1'b0;
        in_data   = '0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset out_data zero", od1, 96'h0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming 0x11, 0x22, 0x33
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            settle("stream");
            if (k > 0) chk("stream literal out_data", od1, vals[k-1]);
            if (k > 0) chk("stream literal noskid out_data", od0, vals[k-1]);
            advance();
        end
        idle_in();
        settle("stream tail");
        chk("stream literal last", od1, 96'h33);
        advance();
        tick("stream drain");

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'hA;
        tick("bp push A");
        in_data   = 96'hB;
        tick("bp push B");
        idle_in();
        out_ready = 1'b1;
        settle("bp pop A");
        chk("bp literal occupancy 2", 96'(oc1), 96'd2);
        chk("bp literal in_ready 0", 96'(ir1), 96'd0);
        chk("bp literal A", od1, 96'hA);
        advance();
        settle("bp pop B");
        chk("bp literal B", od1, 96'hB);
        chk("bp literal in_ready back", 96'(ir1), 96'd1);
        advance();
        tick("bp drain");

        // Hold with occupancy 1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'hC;
        tick("hold fill");
        out_ready = 1'b1;
        hold      = 1'b1;
        in_data   = 96'hF00D;
        for (int k = 0; k < 4; k++) tick("hold");
        idle_in();
        settle("hold release");
        chk("hold literal count", 96'(hc1), 96'd4);
        chk("hold literal data", od1, 96'hC);
        advance();
        tick("hold popped");

        // Flush at occupancy 2, then flush with a real in_fire
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'h1;
        tick("flush fill1");
        in_data   = 96'h2;
        tick("flush fill2");
        flush     = 1'b1;
        in_data   = 96'hD;
        tick("flush full");
        flush     = 1'b0;
        in_data   = 96'h3;
        tick("flush refill");
        flush     = 1'b1;
        in_data   = 96'hD;
        tick("flush with fire");
        idle_in();
        settle("flush after");
        chk("flush literal occupancy", 96'(oc1), 96'd0);
        chk("flush literal out_valid", 96'(ov1), 96'd0);
        advance();

        // Kill
        in_valid = 1'b1;
        kill     = 1'b1;
        in_data  = 96'hE;
        settle("kill");
        chk("kill literal in_ready", 96'(ir1), 96'd1);
        advance();
        idle_in();
        tick("kill after");

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            kill      = ($urandom_range(0, 7) == 0);
            hold      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = {$urandom, $urandom, $urandom};
            tick("random");
        end
        idle_in();

        // Counter saturation (4-bit on the skid instance)
        hold = 1'b1;
        for (int k = 0; k < 20; k++) tick("saturate");
        hold = 1'b0;
        settle("saturate end");
        chk("saturate literal", 96'(hc1), 96'd15);
        advance();

        // Mid-cycle async reset with two beats stored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 96'h5;
        tick("arst fill1");
        in_data   = 96'h6;
        tick("arst fill2");
        idle_in();
        #4;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst asserted");
        chk("arst literal occupancy", 96'(oc1), 96'd0);
        chk("arst literal hold_cycles", 96'(hc1), 96'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick("arst released");
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 96'h77;
        tick("arst resume");
        idle_in();
        tick("arst resume out");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
